// File: rtl/load_store_unit.sv
// Load/store unit: circular store queue and load queue, a single load FSM
// that either forwards from older stores or reads memory, byte-lane
// alignment and sign extension.
// Optional feature macro: LSU_STORE_FORWARD_EN enables store-to-load forwarding.
// Without it, a load waits until every older store has drained to memory.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SQ_DEPTH   = 8,
  parameter int unsigned LQ_DEPTH   = 8,
  parameter int unsigned ROB_WIDTH  = 5,
  parameter int unsigned PHY_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  st_valid,
  input  logic [2:0]            st_funct3,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  ld_valid,
  input  logic [2:0]            ld_funct3,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [ROB_WIDTH-1:0]  ld_rob_id,
  input  logic [PHY_WIDTH-1:0]  ld_rd_phy,
  output logic                  sq_full,
  output logic                  lq_full,
  input  logic                  retire_store_valid,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic                  mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ld_commit_valid,
  output logic [ROB_WIDTH-1:0]  ld_commit_rob_id,
  output logic [PHY_WIDTH-1:0]  ld_commit_rd_phy,
  output logic [DATA_WIDTH-1:0] ld_commit_data
);

  localparam int unsigned SQ_AW = $clog2(SQ_DEPTH);
  localparam int unsigned SQ_PW = SQ_AW + 1;
  localparam int unsigned LQ_AW = $clog2(LQ_DEPTH);
  localparam int unsigned LQ_PW = LQ_AW + 1;
  localparam int unsigned WA_W  = ADDR_WIDTH - 2;

  typedef struct packed {
    logic [WA_W-1:0]       waddr;
    logic [DATA_WIDTH-1:0] data;
    logic [3:0]            strb;
  } sq_entry_t;

  typedef struct packed {
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ROB_WIDTH-1:0]  rob;
    logic [PHY_WIDTH-1:0]  phy;
    logic [SQ_PW-1:0]      snap;
  } lq_entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_MEM_REQ, S_MEM_WAIT, S_RESP
  } state_e;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0:    return 4'b0001 << off;
      3'd1:    return 4'b0011 << off;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_lane(input logic [2:0] f3,
                                                       input logic [1:0] off,
                                                       input logic [DATA_WIDTH-1:0] d);
    case (f3)
      3'd0:    return DATA_WIDTH'(d[7:0]) << {off, 3'b000};
      3'd1:    return DATA_WIDTH'(d[15:0]) << {off, 3'b000};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] f3,
                                                         input logic [1:0] off,
                                                         input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'd0:    return {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'd1:    return {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'd2:    return w;
      3'd4:    return {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'd5:    return {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: return '0;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [SQ_PW-1:0]     sq_wr_q, sq_wr_d, sq_rd_q, sq_rd_d;
  logic [LQ_PW-1:0]     lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
  logic                 sq_full_q, sq_full_d, lq_full_q, lq_full_d;
  sq_entry_t            sq_mem_q [SQ_DEPTH];
  lq_entry_t            lq_mem_q [LQ_DEPTH];

  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] mem_raddr_q, mem_raddr_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [ROB_WIDTH-1:0]  commit_rob_q, commit_rob_d;
  logic [PHY_WIDTH-1:0]  commit_phy_q, commit_phy_d;
  logic [DATA_WIDTH-1:0] commit_data_q, commit_data_d;

  logic sq_empty, sq_full_c, lq_empty, lq_full_c;
  logic sq_push, sq_pop, lq_push, lq_pop;
  sq_entry_t sq_head;
  lq_entry_t lq_head;
  logic [SQ_PW-1:0] snap_dist, sq_count, older_cnt;

  assign sq_empty  = (sq_wr_q == sq_rd_q);
  assign sq_full_c = ((sq_wr_q ^ sq_rd_q) == {1'b1, {SQ_AW{1'b0}}});
  assign lq_empty  = (lq_wr_q == lq_rd_q);
  assign lq_full_c = ((lq_wr_q ^ lq_rd_q) == {1'b1, {LQ_AW{1'b0}}});

  assign sq_push = st_valid && !sq_full_c && !flush;
  assign sq_pop  = retire_store_valid && !sq_empty;
  assign lq_push = ld_valid && !lq_full_c && !flush;
  assign lq_pop  = (state_q == S_RESP);

  assign sq_head = sq_mem_q[sq_rd_q[SQ_AW-1:0]];
  assign lq_head = lq_mem_q[lq_rd_q[LQ_AW-1:0]];

  // Stores still queued that are older than the head load; zero once the head has moved past the snapshot.
  assign snap_dist = lq_head.snap - sq_rd_q;
  assign sq_count  = sq_wr_q - sq_rd_q;
  assign older_cnt = (snap_dist <= sq_count) ? snap_dist : '0;

`ifdef LSU_STORE_FORWARD_EN
  function automatic logic [3:0] load_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0, 3'd4: return 4'b0001 << off;
      3'd1, 3'd5: return 4'b0011 << off;
      3'd2:       return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  logic             fwd_hit, fwd_covered;
  logic [SQ_AW-1:0] fwd_idx;
  sq_entry_t        fwd_entry;
  logic [3:0]       ld_mask;

  // Youngest older store whose word address matches the head load (later iterations win).
  always_comb begin
    fwd_hit = 1'b0;
    fwd_idx = '0;
    for (int unsigned k = 0; k < SQ_DEPTH; k++) begin
      if (SQ_PW'(k) < older_cnt &&
          sq_mem_q[SQ_AW'(sq_rd_q[SQ_AW-1:0] + SQ_AW'(k))].waddr == lq_head.addr[ADDR_WIDTH-1:2]) begin
        fwd_hit = 1'b1;
        fwd_idx = SQ_AW'(sq_rd_q[SQ_AW-1:0] + SQ_AW'(k));
      end
    end
  end

  assign fwd_entry   = sq_mem_q[fwd_idx];
  assign ld_mask     = load_mask(lq_head.funct3, lq_head.addr[1:0]);
  assign fwd_covered = ((fwd_entry.strb & ld_mask) == ld_mask);
`endif

  // Queue pointer updates; flush empties both queues.
  always_comb begin
    sq_wr_d = sq_wr_q + SQ_PW'(sq_push);
    sq_rd_d = sq_rd_q + SQ_PW'(sq_pop);
    lq_wr_d = lq_wr_q + LQ_PW'(lq_push);
    lq_rd_d = lq_rd_q + LQ_PW'(lq_pop);
    if (flush) begin
      sq_wr_d = '0;
      sq_rd_d = '0;
      lq_wr_d = '0;
      lq_rd_d = '0;
    end
    sq_full_d = ((sq_wr_d ^ sq_rd_d) == {1'b1, {SQ_AW{1'b0}}});
    lq_full_d = ((lq_wr_d ^ lq_rd_d) == {1'b1, {LQ_AW{1'b0}}});
  end

  // Retired head store becomes a one-cycle memory write; survives a concurrent flush.
  always_comb begin
    mem_wr_en_d = sq_pop;
    mem_waddr_d = '0;
    mem_wdata_d = '0;
    mem_wstrb_d = '0;
    if (sq_pop) begin
      mem_waddr_d = {sq_head.waddr, 2'b00};
      mem_wdata_d = sq_head.data;
      mem_wstrb_d = sq_head.strb;
    end
  end

  // Load FSM next state and registered request/commit outputs.
  always_comb begin
    state_d        = state_q;
    mem_rd_en_d    = 1'b0;
    mem_raddr_d    = '0;
    commit_valid_d = 1'b0;
    commit_rob_d   = '0;
    commit_phy_d   = '0;
    commit_data_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (!lq_empty) state_d = S_CHECK;
      end
      S_CHECK: begin
`ifdef LSU_STORE_FORWARD_EN
        if (fwd_hit) begin
          if (fwd_covered) begin
            state_d        = S_RESP;
            commit_valid_d = 1'b1;
            commit_rob_d   = lq_head.rob;
            commit_phy_d   = lq_head.phy;
            commit_data_d  = load_extract(lq_head.funct3, lq_head.addr[1:0], fwd_entry.data);
          end
        end else begin
          state_d     = S_MEM_REQ;
          mem_rd_en_d = 1'b1;
          mem_raddr_d = {lq_head.addr[ADDR_WIDTH-1:2], 2'b00};
        end
`else
        if (older_cnt == '0) begin
          state_d     = S_MEM_REQ;
          mem_rd_en_d = 1'b1;
          mem_raddr_d = {lq_head.addr[ADDR_WIDTH-1:2], 2'b00};
        end
`endif
      end
      S_MEM_REQ: begin
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_rdata_valid) begin
          state_d        = S_RESP;
          commit_valid_d = 1'b1;
          commit_rob_d   = lq_head.rob;
          commit_phy_d   = lq_head.phy;
          commit_data_d  = load_extract(lq_head.funct3, lq_head.addr[1:0], mem_rdata);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d        = S_IDLE;
      mem_rd_en_d    = 1'b0;
      mem_raddr_d    = '0;
      commit_valid_d = 1'b0;
      commit_rob_d   = '0;
      commit_phy_d   = '0;
      commit_data_d  = '0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sq_wr_q        <= '0;
      sq_rd_q        <= '0;
      lq_wr_q        <= '0;
      lq_rd_q        <= '0;
      sq_full_q      <= 1'b0;
      lq_full_q      <= 1'b0;
      mem_wr_en_q    <= 1'b0;
      mem_waddr_q    <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= '0;
      mem_rd_en_q    <= 1'b0;
      mem_raddr_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_rob_q   <= '0;
      commit_phy_q   <= '0;
      commit_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      sq_wr_q        <= sq_wr_d;
      sq_rd_q        <= sq_rd_d;
      lq_wr_q        <= lq_wr_d;
      lq_rd_q        <= lq_rd_d;
      sq_full_q      <= sq_full_d;
      lq_full_q      <= lq_full_d;
      mem_wr_en_q    <= mem_wr_en_d;
      mem_waddr_q    <= mem_waddr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrb_q    <= mem_wstrb_d;
      mem_rd_en_q    <= mem_rd_en_d;
      mem_raddr_q    <= mem_raddr_d;
      commit_valid_q <= commit_valid_d;
      commit_rob_q   <= commit_rob_d;
      commit_phy_q   <= commit_phy_d;
      commit_data_q  <= commit_data_d;
    end
  end

  // Queue entry storage; loads snapshot the store tail before any same-cycle store lands.
  always_ff @(posedge clk) begin
    if (sq_push) begin
      sq_mem_q[sq_wr_q[SQ_AW-1:0]] <= '{waddr: st_addr[ADDR_WIDTH-1:2],
                                        data:  store_lane(st_funct3, st_addr[1:0], st_data),
                                        strb:  store_mask(st_funct3, st_addr[1:0])};
    end
    if (lq_push) begin
      lq_mem_q[lq_wr_q[LQ_AW-1:0]] <= '{funct3: ld_funct3, addr: ld_addr, rob: ld_rob_id,
                                        phy: ld_rd_phy, snap: sq_wr_q};
    end
  end

  assign sq_full          = sq_full_q;
  assign lq_full          = lq_full_q;
  assign mem_wr_en        = mem_wr_en_q;
  assign mem_waddr        = mem_waddr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_wstrb        = mem_wstrb_q;
  assign mem_rd_en        = mem_rd_en_q;
  assign mem_raddr        = mem_raddr_q;
  assign ld_commit_valid  = commit_valid_q;
  assign ld_commit_rob_id = commit_rob_q;
  assign ld_commit_rd_phy = commit_phy_q;
  assign ld_commit_data   = commit_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (default parameters).
// Covers both builds: forwarding-specific steps are under LSU_STORE_FORWARD_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr, st_data;
  logic        ld_valid;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_addr;
  logic [4:0]  ld_rob_id;
  logic [5:0]  ld_rd_phy;
  logic        sq_full, lq_full;
  logic        retire_store_valid;
  logic        mem_wr_en;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rd_en;
  logic [31:0] mem_raddr;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        ld_commit_valid;
  logic [4:0]  ld_commit_rob_id;
  logic [5:0]  ld_commit_rd_phy;
  logic [31:0] ld_commit_data;

  int n_tests = 0;
  int n_fail  = 0;
  int commit_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .st_valid(st_valid), .st_funct3(st_funct3), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_funct3(ld_funct3), .ld_addr(ld_addr),
    .ld_rob_id(ld_rob_id), .ld_rd_phy(ld_rd_phy),
    .sq_full(sq_full), .lq_full(lq_full),
    .retire_store_valid(retire_store_valid),
    .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .ld_commit_valid(ld_commit_valid), .ld_commit_rob_id(ld_commit_rob_id),
    .ld_commit_rd_phy(ld_commit_rd_phy), .ld_commit_data(ld_commit_data)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    commit_cnt += int'(ld_commit_valid);
    rd_cnt     += int'(mem_rd_en);
    wr_cnt     += int'(mem_wr_en);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_funct3 = f3; st_addr = a; st_data = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic push_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rob, input logic [5:0] phy);
    ld_valid = 1'b1; ld_funct3 = f3; ld_addr = a; ld_rob_id = rob; ld_rd_phy = phy;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic retire_one();
    retire_store_valid = 1'b1;
    tick();
    retire_store_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    check({tag, "_wr_en"}, 64'(mem_wr_en), 64'(1));
    check({tag, "_waddr"}, 64'(mem_waddr), 64'(a));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(d));
    check({tag, "_wstrb"}, 64'(mem_wstrb), 64'(s));
  endtask

  task automatic check_commit(input string tag, input logic [4:0] rob, input logic [5:0] phy,
                              input logic [31:0] d);
    check({tag, "_cvalid"}, 64'(ld_commit_valid), 64'(1));
    check({tag, "_rob"}, 64'(ld_commit_rob_id), 64'(rob));
    check({tag, "_phy"}, 64'(ld_commit_rd_phy), 64'(phy));
    check({tag, "_data"}, 64'(ld_commit_data), 64'(d));
  endtask

  task automatic wait_rd(input string tag, input logic [31:0] exp_addr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_en) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_rd_seen"}, 64'(seen), 64'(1));
    if (seen) check({tag, "_raddr"}, 64'(mem_raddr), 64'(exp_addr));
  endtask

  task automatic mem_respond(input logic [31:0] d);
    tick();
    mem_rdata_valid = 1'b1; mem_rdata = d;
    tick();
    mem_rdata_valid = 1'b0;
  endtask

  task automatic do_mem_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [4:0] rob, input logic [5:0] phy,
                             input logic [31:0] rdata, input logic [31:0] exp_d);
    push_load(f3, a, rob, phy);
    wait_rd(tag, a & 32'hFFFF_FFFC);
    mem_respond(rdata);
    check_commit(tag, rob, phy, exp_d);
  endtask

  initial begin
    int c0, r0, w0;
    rst_n = 1'b0; flush = 1'b0;
    st_valid = 1'b0; st_funct3 = '0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_funct3 = '0; ld_addr = '0; ld_rob_id = '0; ld_rd_phy = '0;
    retire_store_valid = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    repeat (3) tick();

    // Reset state
    check("rst_sq_full", 64'(sq_full), 64'(0));
    check("rst_lq_full", 64'(lq_full), 64'(0));
    check("rst_wr_en", 64'(mem_wr_en), 64'(0));
    check("rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_commit", 64'(ld_commit_valid), 64'(0));
    check("rst_waddr", 64'(mem_waddr), 64'(0));
    rst_n = 1'b1;
    tick();

    // SW 0x100 = DEADBEEF then LW 0x100 (rob 3, phy 9)
    push_store(3'd2, 32'h100, 32'hDEADBEEF);
    r0 = rd_cnt;
    push_load(3'd2, 32'h100, 5'd3, 6'd9);
`ifdef LSU_STORE_FORWARD_EN
    tick();
    check("a_lat_n2", 64'(ld_commit_valid), 64'(0));
    tick();
    check_commit("a_fwd", 5'd3, 6'd9, 32'hDEADBEEF);
    check("a_no_rd", 64'(rd_cnt - r0), 64'(0));
    tick();
    check("a_pulse", 64'(ld_commit_valid), 64'(0));
    retire_one();
    check_write("a_wr", 32'h100, 32'hDEADBEEF, 4'hF);
`else
    retire_one();
    check_write("a_wr", 32'h100, 32'hDEADBEEF, 4'hF);
    wait_rd("a", 32'h100);
    mem_respond(32'hDEADBEEF);
    check_commit("a_mem", 5'd3, 6'd9, 32'hDEADBEEF);
    tick();
    check("a_pulse", 64'(ld_commit_valid), 64'(0));
`endif
    tick();
    check("a_wr_pulse", 64'(mem_wr_en), 64'(0));

    // SB 0x101 = AA then LW 0x100: stall until the store retires
    push_store(3'd0, 32'h101, 32'h0000_00AA);
    c0 = commit_cnt; r0 = rd_cnt;
    push_load(3'd2, 32'h100, 5'd4, 6'd10);
    repeat (5) tick();
    check("b_stall_rd", 64'(rd_cnt - r0), 64'(0));
    check("b_stall_commit", 64'(commit_cnt - c0), 64'(0));
    retire_one();
    check_write("b_wr", 32'h100, 32'h0000_AA00, 4'b0010);
    wait_rd("b", 32'h100);
    mem_respond(32'h11AA2233);
    check_commit("b", 5'd4, 6'd10, 32'h11AA2233);

    // Memory loads: sign/zero extension and lane selection from 0x80112233
    do_mem_load("c_lb", 3'd0, 32'h103, 5'd1, 6'd2, 32'h80112233, 32'hFFFFFF80);
    do_mem_load("c_lbu", 3'd4, 32'h103, 5'd2, 6'd3, 32'h80112233, 32'h00000080);
    do_mem_load("c_lh", 3'd1, 32'h102, 5'd5, 6'd4, 32'h80112233, 32'hFFFF8011);
    do_mem_load("c_lhu", 3'd5, 32'h102, 5'd6, 6'd5, 32'h80112233, 32'h00008011);
    do_mem_load("c_lb0", 3'd0, 32'h100, 5'd7, 6'd6, 32'h80112233, 32'h00000033);
    do_mem_load("c_rsv", 3'd3, 32'h100, 5'd8, 6'd7, 32'h80112233, 32'h00000000);

    // Two stores to 0x200, then LW 0x200 returns the younger value
    push_store(3'd2, 32'h200, 32'd1);
    push_store(3'd2, 32'h200, 32'd2);
    r0 = rd_cnt;
    push_load(3'd2, 32'h200, 5'd11, 6'd12);
`ifdef LSU_STORE_FORWARD_EN
    tick();
    tick();
    check_commit("d_fwd", 5'd11, 6'd12, 32'd2);
    check("d_no_rd", 64'(rd_cnt - r0), 64'(0));
    retire_one();
    check_write("d_wr1", 32'h200, 32'd1, 4'hF);
    retire_one();
    check_write("d_wr2", 32'h200, 32'd2, 4'hF);
    push_store(3'd2, 32'h300, 32'h11223344);
    push_load(3'd1, 32'h302, 5'd12, 6'd13);
    tick();
    tick();
    check_commit("d_fwd_lh", 5'd12, 6'd13, 32'h00001122);
    retire_one();
    check_write("d_wr3", 32'h300, 32'h11223344, 4'hF);
`else
    retire_one();
    check_write("d_wr1", 32'h200, 32'd1, 4'hF);
    retire_one();
    check_write("d_wr2", 32'h200, 32'd2, 4'hF);
    wait_rd("d", 32'h200);
    mem_respond(32'd2);
    check_commit("d_mem", 5'd11, 6'd12, 32'd2);
`endif
    repeat (2) tick();

    // Fill the SQ, drop an extra store, simultaneous retire+enqueue, wrap
    for (int i = 0; i < 8; i++) begin
      push_store(3'd2, 32'h400 + 32'(4 * i), 32'(i));
      if (i == 6) check("e_not_full7", 64'(sq_full), 64'(0));
    end
    check("e_full8", 64'(sq_full), 64'(1));
    push_store(3'd2, 32'h480, 32'h99);
    check("e_full_drop", 64'(sq_full), 64'(1));
    retire_one();
    check_write("e_r0", 32'h400, 32'd0, 4'hF);
    check("e_full_after_pop", 64'(sq_full), 64'(0));
    st_valid = 1'b1; st_funct3 = 3'd2; st_addr = 32'h420; st_data = 32'd8;
    retire_store_valid = 1'b1;
    tick();
    st_valid = 1'b0; retire_store_valid = 1'b0;
    check_write("e_r1", 32'h404, 32'd1, 4'hF);
    check("e_same_count", 64'(sq_full), 64'(0));
    push_store(3'd2, 32'h424, 32'd9);
    check("e_full_again", 64'(sq_full), 64'(1));
    for (int j = 2; j < 10; j++) begin
      retire_one();
      check_write($sformatf("e_r%0d", j),
                  (j < 8) ? 32'h400 + 32'(4 * j) : 32'h420 + 32'(4 * (j - 8)), 32'(j), 4'hF);
    end
    check("e_drained", 64'(sq_full), 64'(0));
    retire_one();
    check("e_empty_retire", 64'(mem_wr_en), 64'(0));

    // Fill the LQ behind a blocked load, then flush everything
    push_store(3'd0, 32'h500, 32'h55);
    for (int i = 0; i < 8; i++) begin
      push_load(3'd2, 32'h500, 5'(i), 6'(i));
      if (i == 6) check("g_lq_not_full7", 64'(lq_full), 64'(0));
    end
    check("g_lq_full8", 64'(lq_full), 64'(1));
    c0 = commit_cnt; r0 = rd_cnt; w0 = wr_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("g_sq_empty", 64'(sq_full), 64'(0));
    check("g_lq_empty", 64'(lq_full), 64'(0));
    repeat (4) tick();
    check("g_no_commit", 64'(commit_cnt - c0), 64'(0));
    check("g_no_rd", 64'(rd_cnt - r0), 64'(0));
    check("g_no_wr", 64'(wr_cnt - w0), 64'(0));
    retire_one();
    check("g_retire_empty", 64'(mem_wr_en), 64'(0));

    // Retire and flush together: the committed store is still written
    push_store(3'd2, 32'h700, 32'h77);
    retire_store_valid = 1'b1; flush = 1'b1;
    tick();
    retire_store_valid = 1'b0; flush = 1'b0;
    check_write("h_flush_wr", 32'h700, 32'h77, 4'hF);

    // Flush during MEM_WAIT, then a stale response is discarded
    push_load(3'd2, 32'h600, 5'd7, 6'd7);
    wait_rd("f", 32'h600);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    c0 = commit_cnt;
    mem_rdata_valid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rdata_valid = 1'b0;
    repeat (3) tick();
    check("f_no_commit", 64'(commit_cnt - c0), 64'(0));
    check("f_lq_full", 64'(lq_full), 64'(0));
    do_mem_load("f_next", 3'd2, 32'h604, 5'd8, 6'd12, 32'hCAFEF00D, 32'hCAFEF00D);

    // Reset mid-transaction abandons the load
    push_load(3'd2, 32'h800, 5'd9, 6'd9);
    wait_rd("r", 32'h800);
    tick();
    rst_n = 1'b0;
    c0 = commit_cnt;
    tick();
    check("r_rst_rd", 64'(mem_rd_en), 64'(0));
    mem_rdata_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_rdata_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
    check("r_no_commit", 64'(commit_cnt - c0), 64'(0));
    do_mem_load("r_next", 3'd2, 32'h804, 5'd10, 6'd20, 32'h0BADF00D, 32'h0BADF00D);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is legal.
REQ-003 SHALL have parameters SQ_DEPTH and LQ_DEPTH, default 8 each, queue depths; each SHALL be a power of two, at least 2.
REQ-004 SHALL have parameters ROB_WIDTH, default 5, and PHY_WIDTH, default 6, for ROB tag and physical-register widths.
REQ-005 Ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous squash.
- st_valid/st_funct3/st_addr/st_data  in  1/3/ADDR_WIDTH/DATA_WIDTH  store enqueue.
- ld_valid/ld_funct3/ld_addr/ld_rob_id/ld_rd_phy  in  1/3/ADDR_WIDTH/ROB_WIDTH/PHY_WIDTH  load enqueue.
- sq_full, lq_full  out  1  queue full.
- retire_store_valid  in  1  head store is architecturally committed.
- mem_wr_en/mem_waddr/mem_wdata/mem_wstrb  out  1/ADDR_WIDTH/DATA_WIDTH/4  store write.
- mem_rd_en/mem_raddr  out  1/ADDR_WIDTH  load read request.
- mem_rdata_valid/mem_rdata  in  1/DATA_WIDTH  read response.
- ld_commit_valid/ld_commit_rob_id/ld_commit_rd_phy/ld_commit_data  out  1/ROB_WIDTH/PHY_WIDTH/DATA_WIDTH  load writeback.

Function
REQ-006 Both queues SHALL be circular FIFOs with pointers of log2(depth)+1 bits; full = pointers differ only in MSB; empty = pointers equal.
REQ-007 Enqueue while the queue is full SHALL be dropped with no state change.
REQ-008 Store entry SHALL hold the word address (addr[ADDR_WIDTH-1:2]), the byte mask from funct3 (SB 1 byte, SH 2 bytes, SW 4 bytes), and the lane-shifted data.
REQ-009 Load entry SHALL hold funct3, addr, rob_id, rd_phy, and a snapshot of the store tail pointer taken at enqueue; stores enqueued in the same cycle SHALL count as younger.
REQ-010 retire_store_valid with the SQ non-empty SHALL pop the head and drive mem_wr_en=1 with that entry's address, data and mask on the next cycle, for exactly one cycle; with the SQ empty it SHALL be ignored.
REQ-011 Load FSM states: IDLE, CHECK, MEM_REQ, MEM_WAIT, RESP.
REQ-012 IDLE->CHECK when the LQ is non-empty.
REQ-013 CHECK scans SQ entries older than the head load's snapshot and selects the youngest whose word address matches.
- Selected entry's mask covers the load bytes: ->RESP with forwarded data.
- Match but partial coverage: stay in CHECK until that store retires.
- No match: ->MEM_REQ.
REQ-014 MEM_REQ SHALL assert mem_rd_en for one cycle with mem_raddr = word-aligned load address, then go to MEM_WAIT.
REQ-015 MEM_WAIT SHALL wait for mem_rdata_valid, latch the data, then go to RESP.
REQ-016 RESP SHALL assert ld_commit_valid for exactly one cycle, pop the LQ head, and return to IDLE.
REQ-017 Forwarded-load latency: enqueue at cycle N -> ld_commit_valid at N+3.
REQ-018 Load data SHALL be extracted by addr[1:0]: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged; reserved funct3 SHALL return 0.
REQ-019 Simultaneous store enqueue and retire SHALL leave the SQ count unchanged; the same holds for load enqueue and pop on the LQ.
REQ-020 flush SHALL empty both queues and force the FSM to IDLE.
- A mem_wr_en already scheduled by a retire SHALL still be issued.
- A pending mem_rdata_valid SHALL be discarded.

Reset
REQ-021 While rst_n=0, all pointers SHALL be 0, the FSM SHALL be IDLE, and every output SHALL be 0 except sq_full=lq_full=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it with no commit and no write.

Configuration
REQ-023 Macro LSU_STORE_FORWARD_EN.
- Defined: forwarding per REQ-013.
- Undefined: CHECK SHALL wait until the SQ head pointer equals the load snapshot (all older stores drained), then go to MEM_REQ; no forwarding logic SHALL be synthesized.

Verification
REQ-024 SW 0x100=0xDEADBEEF, then LW 0x100 (rob 3, phy 9) -> commit rob 3, phy 9, data 0xDEADBEEF, no mem_rd_en (with forwarding enabled).
REQ-025 SB 0x101=0xAA, then LW 0x100 -> CHECK stalls; after retire, mem_wr_en with wstrb=0010; then mem_rd_en at 0x100.
REQ-026 LB 0x103 with no stores, mem_rdata=0x80112233 -> data 0xFFFFFF80; LBU -> 0x00000080.
REQ-027 SW 0x200=1, then SW 0x200=2, then LW 0x200 -> data 2 (youngest older store).
REQ-028 Fill the SQ to SQ_DEPTH -> sq_full=1 and an extra store is dropped; retire and enqueue in the same cycle -> count unchanged; pointers wrap correctly.
REQ-029 flush during MEM_WAIT, then mem_rdata_valid -> no ld_commit_valid; both queues empty; FSM IDLE.
